// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the EX stage and muldiv_seq.
//   master (pipeline side) drives start/op/a/b/flush/hi_we/lo_we/wdata.
//   slave  (muldiv_seq)    drives busy/done/hi/lo.
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, flush, hi_we, lo_we, wdata,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, flush, hi_we, lo_we, wdata,
                  output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : muldiv_if.slave (start/op/a/b/flush/MTHI/MTLO in,
//               busy/done/hi/lo out)
//   DIV_ZERO_LO : LO value produced by a divide by zero
// Optional: define MULDIV_EARLY_OUT_EN to end a multiply once the remaining
// multiplier bits are all zero (divide latency is unaffected).
module muldiv_seq #(
  parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic        bz_q, bz_d;            // divisor was zero
  logic [63:0] acc_q, acc_d;          // product accumulator / remainder (low 33 bits)
  logic [63:0] mcand_q, mcand_d;      // shifting multiplicand / divisor (low 32 bits)
  logic [31:0] mplr_q, mplr_d;        // multiplier / dividend shifting into quotient
  logic        busy_q, busy_d, done_q, done_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  // Operand conditioning for a new request: ops 00/10 are signed.
  logic        in_signed;
  logic [31:0] a_mag, b_mag;
  assign in_signed = ~bus.op[0];
  assign a_mag = (in_signed && bus.a[31]) ? -bus.a : bus.a;
  assign b_mag = (in_signed && bus.b[31]) ? -bus.b : bus.b;

  // Restoring-division step: shift {rem,quot} left, trial-subtract divisor.
  logic [32:0] div_shl;
  logic [33:0] div_trial;
  assign div_shl   = {acc_q[31:0], mplr_q[31]};
  assign div_trial = {1'b0, div_shl} - {2'b00, mcand_q[31:0]};

  // Sign correction applied in FIX.
  logic        op_signed, neg_res;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;
  assign op_signed = ~op_q[0];
  assign neg_res   = op_signed & (sa_q ^ sb_q);
  assign prod_fix  = neg_res ? -acc_q : acc_q;
  assign quot_fix  = neg_res ? -mplr_q : mplr_q;
  // With a zero divisor the remainder path reproduces the raw dividend.
  assign rem_fix   = (op_signed & sa_q) ? -acc_q[31:0] : acc_q[31:0];

  logic mul_last, mul_skip;
`ifdef MULDIV_EARLY_OUT_EN
  assign mul_last = (cnt_q == 6'd31) || (mplr_q[31:1] == 31'd0);
  assign mul_skip = (b_mag == 32'd0);
`else
  assign mul_last = (cnt_q == 6'd31);
  assign mul_skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          sa_d    = bus.a[31];
          sb_d    = bus.b[31];
          bz_d    = (bus.b == 32'd0);
          cnt_d   = 6'd0;
          busy_d  = 1'b1;
          if (bus.op[1]) begin
            acc_d   = 64'd0;
            mcand_d = {32'd0, b_mag};
            mplr_d  = a_mag;
            state_d = DIV;
          end else begin
            acc_d   = 64'd0;
            mcand_d = {32'd0, a_mag};
            mplr_d  = b_mag;
            state_d = mul_skip ? FIX : MUL;
          end
        end
      end
      MUL: begin
        if (mplr_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = {mcand_q[62:0], 1'b0};
        mplr_d  = {1'b0, mplr_q[31:1]};
        cnt_d   = cnt_q + 6'd1;
        if (mul_last) state_d = FIX;
      end
      DIV: begin
        if (!div_trial[33]) begin
          acc_d  = {31'd0, div_trial[32:0]};
          mplr_d = {mplr_q[30:0], 1'b1};
        end else begin
          acc_d  = {31'd0, div_shl};
          mplr_d = {mplr_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        if (op_q[1]) begin
          hi_d = rem_fix;
          lo_d = bz_q ? DIV_ZERO_LO : quot_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush beats everything in flight, including a same-cycle start.
    if (bus.flush) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    // MTHI/MTLO only land while the unit is idle and not being started.
    if (!busy_q && !bus.start) begin
      if (bus.hi_we) hi_d = bus.wdata;
      if (bus.lo_we) lo_d = bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 2'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      acc_q   <= 64'd0;
      mcand_q <= 64'd0;
      mplr_q  <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq.
// Cycle k = interval after the k-th rising edge following the request cycle.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  int   dcyc, bcnt, dpulses;

  muldiv_if bus();
  muldiv_seq #(.DIV_ZERO_LO(32'hFFFF_FFFF)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO = 1;
`else
  localparam int EO = 0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Issue a request in the current cycle (cycle 0), then follow it until done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int dc, output int bc);
    bus.op = o; bus.a = x; bus.b = y; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    dc = -1; bc = 0;
    for (int c = 1; c <= 60 && dc < 0; c++) begin
      if (bus.busy) bc++;
      if (bus.done) dc = c;
      else tick();
    end
  endtask

  // Count done pulses over n cycles.
  task automatic watch_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.done) cnt++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.flush = 0;
    bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
    tick(); tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    rst = 1'b0;
    tick();

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dcyc, bcnt);
    chk("multu_max_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    chk("multu_max_done_cyc", dcyc, 34);
    chk("multu_max_busy_cycles", bcnt, 33);

    do_op(2'b00, -32'sd3, 32'd7, dcyc, bcnt);
    chk("mult_neg_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mult_neg_done_cyc", dcyc, EO ? 5 : 34);

    // Issued in the done cycle of the previous op: back-to-back accept.
    do_op(2'b10, -32'sd7, 32'd2, dcyc, bcnt);
    chk("div_neg_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_neg_done_cyc", dcyc, 34);
    chk("div_b2b_busy_cycles", bcnt, 33);

    do_op(2'b11, 32'd7, 32'd2, dcyc, bcnt);
    chk("divu_hilo", {bus.hi, bus.lo}, {32'd1, 32'd3});
    chk("divu_done_cyc", dcyc, 34);

    do_op(2'b10, 32'd5, 32'd0, dcyc, bcnt);
    chk("div_by_zero_hilo", {bus.hi, bus.lo}, {32'd5, 32'hFFFF_FFFF});
    chk("div_by_zero_done_cyc", dcyc, 34);

    do_op(2'b10, -32'sd5, 32'd0, dcyc, bcnt);
    chk("div_neg_by_zero_hilo", {bus.hi, bus.lo}, {32'hFFFF_FFFB, 32'hFFFF_FFFF});

    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, dcyc, bcnt);
    chk("div_intmin_hilo", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});

    // Simultaneous MTHI/MTLO, then MTHI alone.
    bus.hi_we = 1; bus.lo_we = 1; bus.wdata = 32'h55;
    tick();
    bus.lo_we = 0; bus.wdata = 32'h1234;
    chk("mthi_mtlo_both", {bus.hi, bus.lo}, {32'h55, 32'h55});
    tick();
    bus.hi_we = 0;
    chk("mthi_only", {bus.hi, bus.lo}, {32'h1234, 32'h55});

    // MTHI blocked while a start is presented.
    bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1;
    bus.hi_we = 1; bus.wdata = 32'hDEAD;
    tick();                                   // cycle 1
    bus.start = 0; bus.hi_we = 0;
    chk("mthi_with_start_ignored", bus.hi, 32'h1234);
    tick(); tick();                           // cycle 3
    bus.hi_we = 1; bus.wdata = 32'hBEEF;
    tick();                                   // cycle 4
    bus.hi_we = 0;
    chk("mthi_busy_ignored", bus.hi, 32'h1234);
    tick();                                   // cycle 5
    bus.start = 1; bus.op = 2'b01;
    tick();                                   // cycle 6
    bus.start = 0;
    repeat (4) tick();                        // cycle 10
    chk("busy_before_flush", bus.busy, 1);
    bus.flush = 1;
    tick();                                   // cycle 11
    bus.flush = 0;
    chk("flush_busy", bus.busy, 0);
    chk("flush_done", bus.done, 0);
    watch_done(45, dpulses);
    chk("flush_no_done", dpulses, 0);
    chk("flush_hilo_kept", {bus.hi, bus.lo}, {32'h1234, 32'h55});

    // Flush and start together: request dropped.
    bus.start = 1; bus.flush = 1; bus.op = 2'b00; bus.a = 32'd2; bus.b = 32'd3;
    tick();
    bus.start = 0; bus.flush = 0;
    chk("flush_start_busy", bus.busy, 0);
    watch_done(40, dpulses);
    chk("flush_start_no_done", dpulses, 0);

    // Reset in cycle 5 of a MULT.
    bus.start = 1; bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd5;
    tick();
    bus.start = 0;
    repeat (4) tick();                        // cycle 5
    rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_outputs", {bus.busy, bus.done, bus.hi, bus.lo}, 66'd0);
    watch_done(40, dpulses);
    chk("rst_mid_no_done", dpulses, 0);

    do_op(2'b01, 32'd9, 32'd3, dcyc, bcnt);
    chk("multu_small_hilo", {bus.hi, bus.lo}, {32'd0, 32'd27});
    chk("multu_small_done_cyc", dcyc, EO ? 4 : 34);

    do_op(2'b01, 32'd9, 32'd0, dcyc, bcnt);
    chk("multu_zero_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("multu_zero_done_cyc", dcyc, EO ? 2 : 34);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
